// File: rtl/operand_sel_if.sv
// Handshake bundle for operand_sel_stage: upstream offer, downstream
// result and the sticky select-error flag.
interface operand_sel_if #(
    parameter int W      = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*W-1:0] in_data;
    logic [SEL_W-1:0]    in_sel;
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        out_data;
    logic [SEL_W-1:0]    out_sel;
    logic                out_valid;
    logic                out_ready;
    logic                sel_err;

    // The stage itself.
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid, sel_err
    );

    // Whoever drives the stage and consumes its output.
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid, sel_err
    );
endinterface

// File: rtl/operand_sel_stage.sv
// Registered N-way operand selector with a 2-entry skid buffer.
// MAIN drives the outputs, SKID absorbs one beat while downstream stalls,
// so in_ready comes straight from a flop. Flush squashes both entries.
module operand_sel_stage #(
    parameter int W      = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    operand_sel_if.slave  bus
);
    localparam logic [SEL_W:0] NUM_IN_C = (SEL_W+1)'(NUM_IN);

    logic [W-1:0]     r_main_data, r_skid_data;
    logic [SEL_W-1:0] r_main_sel,  r_skid_sel;
    logic             r_main_valid, r_skid_valid;
    logic             r_in_ready;
    logic             r_sel_err;

    logic [W-1:0]     w_sel_data;
    logic             w_sel_ok;
    logic             w_accept;
    logic             w_consume;

    logic [W-1:0]     w_main_data_nxt, w_skid_data_nxt;
    logic [SEL_W-1:0] w_main_sel_nxt,  w_skid_sel_nxt;
    logic             w_main_valid_nxt, w_skid_valid_nxt;

    assign w_sel_ok  = ({1'b0, bus.in_sel} < NUM_IN_C);
    assign w_accept  = bus.in_valid & r_in_ready;
    assign w_consume = r_main_valid & bus.out_ready;

    // Pick the addressed input; an out-of-range select yields zero, never an alias.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                w_sel_data = bus.in_data[k*W +: W];
            end
        end
    end

    // Next-state of the two entries; FIFO order, no bubble on accept+consume.
    always_comb begin
        w_main_data_nxt  = r_main_data;
        w_main_sel_nxt   = r_main_sel;
        w_main_valid_nxt = r_main_valid;
        w_skid_data_nxt  = r_skid_data;
        w_skid_sel_nxt   = r_skid_sel;
        w_skid_valid_nxt = r_skid_valid;

        if (flush) begin
            // Payload registers keep their value; only the valids are squashed.
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid) begin
            if (w_accept) begin
                w_main_data_nxt  = w_sel_data;
                w_main_sel_nxt   = bus.in_sel;
                w_main_valid_nxt = 1'b1;
            end
        end else if (w_consume) begin
            if (r_skid_valid) begin
                w_main_data_nxt  = r_skid_data;
                w_main_sel_nxt   = r_skid_sel;
                w_skid_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_main_data_nxt  = w_sel_data;
                w_main_sel_nxt   = bus.in_sel;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_data_nxt  = w_sel_data;
            w_skid_sel_nxt   = bus.in_sel;
            w_skid_valid_nxt = 1'b1;
        end
    end

    // Entry state, registered ready and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload registers are reset too because out_data/out_sel
            // must read zero after reset; this is two words, not a RAM.
            r_main_data  <= '0;
            r_main_sel   <= '0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_sel   <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_sel_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_main_data  <= w_main_data_nxt;
            r_main_sel   <= w_main_sel_nxt;
            r_main_valid <= w_main_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_skid_sel   <= w_skid_sel_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
            if (w_accept && !w_sel_ok) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    assign bus.out_data  = r_main_data;
    assign bus.out_sel   = r_main_sel;
    assign bus.out_valid = r_main_valid;
    assign bus.in_ready  = r_in_ready;
    assign bus.sel_err   = r_sel_err;
endmodule

// File: tb/tb_operand_sel_stage.sv
// Directed bench for operand_sel_stage: one 4-input and one 3-input instance.
module tb_operand_sel_stage;
    logic clk;
    logic rst_n;
    logic flush;

    int n_checks;
    int n_fail;

    operand_sel_if #(.W(32), .NUM_IN(4)) bus4 ();
    operand_sel_if #(.W(32), .NUM_IN(3)) bus3 ();

    operand_sel_stage #(.W(32), .NUM_IN(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus4)
    );

    operand_sel_stage #(.W(32), .NUM_IN(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dval(input int k);
        return 32'hC0DE_0000 + 32'(k) * 32'h0000_0101;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        bus4.in_data = '0; bus4.in_sel = '0; bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
        bus3.in_data = '0; bus3.in_sel = '0; bus3.in_valid = 1'b0; bus3.out_ready = 1'b0;

        // Reset values
        step();
        check("rst_out_valid", 64'(bus4.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus4.in_ready),  64'd1);
        check("rst_out_data",  64'(bus4.out_data),  64'd0);
        check("rst_out_sel",   64'(bus4.out_sel),   64'd0);
        check("rst_sel_err",   64'(bus4.sel_err),   64'd0);
        rst_n = 1'b1;
        step();

        // 1. Single beat, one-cycle latency
        bus4.in_data   = {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0};
        bus4.in_sel    = 2'd2;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b1;
        step();
        bus4.in_valid = 1'b0;
        check("t1_out_valid", 64'(bus4.out_valid), 64'd1);
        check("t1_out_data",  64'(bus4.out_data),  64'hDEAD_BEEF);
        check("t1_out_sel",   64'(bus4.out_sel),   64'd2);

        // 2. Back-to-back stream sel=0..3, no bubble
        bus4.in_data = {dval(3), dval(2), dval(1), dval(0)};
        for (int i = 0; i < 4; i++) begin
            bus4.in_sel   = 2'(i);
            bus4.in_valid = 1'b1;
            step();
            check($sformatf("t2_valid_%0d", i), 64'(bus4.out_valid), 64'd1);
            check($sformatf("t2_data_%0d", i),  64'(bus4.out_data),  64'(dval(i)));
            check($sformatf("t2_sel_%0d", i),   64'(bus4.out_sel),   64'(i));
            check($sformatf("t2_ready_%0d", i), 64'(bus4.in_ready),  64'd1);
        end
        bus4.in_valid = 1'b0;
        step();
        check("t2_drain", 64'(bus4.out_valid), 64'd0);

        // 3. Stall: A held, B parked in skid, then drained in order
        bus4.out_ready = 1'b0;
        bus4.in_data   = {32'hBBBB_0003, 32'h0, 32'hAAAA_0001, 32'h0};
        bus4.in_sel    = 2'd1;
        bus4.in_valid  = 1'b1;
        step();
        check("t3_a_data",  64'(bus4.out_data), 64'hAAAA_0001);
        check("t3_a_ready", 64'(bus4.in_ready), 64'd1);
        bus4.in_sel = 2'd3;
        step();
        bus4.in_valid = 1'b0;
        check("t3_b_ready", 64'(bus4.in_ready), 64'd0);
        check("t3_a_hold",  64'(bus4.out_data), 64'hAAAA_0001);
        check("t3_a_sel",   64'(bus4.out_sel),  64'd1);
        step();
        check("t3_a_hold2", 64'(bus4.out_data), 64'hAAAA_0001);
        check("t3_a_vld2",  64'(bus4.out_valid), 64'd1);
        bus4.out_ready = 1'b1;
        step();
        check("t3_b_data",   64'(bus4.out_data),  64'hBBBB_0003);
        check("t3_b_sel",    64'(bus4.out_sel),   64'd3);
        check("t3_b_valid",  64'(bus4.out_valid), 64'd1);
        check("t3_ready_up", 64'(bus4.in_ready),  64'd1);
        step();
        check("t3_empty", 64'(bus4.out_valid), 64'd0);

        // 4. Flush with both entries full and C offered
        bus4.out_ready = 1'b0;
        bus4.in_sel    = 2'd1;
        bus4.in_valid  = 1'b1;
        step();
        bus4.in_sel = 2'd3;
        step();
        check("t4_full", 64'(bus4.in_ready), 64'd0);
        bus4.in_data = {32'h0, 32'h0, 32'h0, 32'hCCCC_0000};
        bus4.in_sel  = 2'd0;
        flush        = 1'b1;
        step();
        flush         = 1'b0;
        bus4.in_valid = 1'b0;
        check("t4_valid", 64'(bus4.out_valid), 64'd0);
        check("t4_ready", 64'(bus4.in_ready),  64'd1);
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t4_no_c_%0d", i), 64'(bus4.out_valid), 64'd0);
        end

        // 4b. Beat accepted in the flush cycle is discarded
        bus4.out_ready = 1'b0;
        bus4.in_data   = {32'h0, 32'h0, 32'h1234_5678, 32'hCCCC_0000};
        bus4.in_sel    = 2'd1;
        bus4.in_valid  = 1'b1;
        step();
        check("t4b_main", 64'(bus4.out_data), 64'h1234_5678);
        bus4.in_sel = 2'd0;
        flush       = 1'b1;
        step();
        flush         = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        check("t4b_valid", 64'(bus4.out_valid), 64'd0);
        check("t4b_ready", 64'(bus4.in_ready),  64'd1);
        step();
        check("t4b_no_c", 64'(bus4.out_valid), 64'd0);

        // 5. Out-of-range select on the 3-input instance
        bus3.in_data   = {32'h3333_2222, 32'h3333_1111, 32'h3333_0000};
        bus3.out_ready = 1'b1;
        check("t5_err_pre", 64'(bus3.sel_err), 64'd0);
        bus3.in_sel   = 2'd3;
        bus3.in_valid = 1'b1;
        step();
        check("t5_valid", 64'(bus3.out_valid), 64'd1);
        check("t5_data",  64'(bus3.out_data),  64'd0);
        check("t5_err",   64'(bus3.sel_err),   64'd1);
        bus3.in_sel = 2'd1;
        step();
        bus3.in_valid = 1'b0;
        check("t5_ok_data", 64'(bus3.out_data), 64'h3333_1111);
        check("t5_err_hold", 64'(bus3.sel_err), 64'd1);
        step();
        check("t5_err_idle", 64'(bus3.sel_err), 64'd1);

        // 6. Async reset mid-stall with both entries full
        bus4.out_ready = 1'b0;
        bus3.out_ready = 1'b0;
        bus4.in_data   = {dval(3), dval(2), dval(1), dval(0)};
        bus4.in_sel    = 2'd0;
        bus4.in_valid  = 1'b1;
        bus3.in_sel    = 2'd0;
        bus3.in_valid  = 1'b1;
        step();
        bus4.in_sel = 2'd1;
        bus3.in_sel = 2'd2;
        step();
        bus4.in_valid = 1'b0;
        bus3.in_valid = 1'b0;
        check("t6_full4",  64'(bus4.in_ready), 64'd0);
        check("t6_full3",  64'(bus3.in_ready), 64'd0);
        check("t6_data4",  64'(bus4.out_data), 64'(dval(0)));
        check("t6_err3",   64'(bus3.sel_err),  64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid4", 64'(bus4.out_valid), 64'd0);
        check("t6_ready4", 64'(bus4.in_ready),  64'd1);
        check("t6_data4z", 64'(bus4.out_data),  64'd0);
        check("t6_valid3", 64'(bus3.out_valid), 64'd0);
        check("t6_ready3", 64'(bus3.in_ready),  64'd1);
        check("t6_err3z",  64'(bus3.sel_err),   64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_post_valid4", 64'(bus4.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
